// File: rtl/fc_argmax_classifier.sv
// Argmax stage after the FC+ReLU layer: captures all class scores, scans one per cycle.
// Optional FC_ARGMAX_TOP2_EN adds runner-up index and best-minus-second margin.
module fc_argmax_classifier #(
    parameter int N_CLASS = 10,
    parameter int DW      = 16,
    parameter int IDXW    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [N_CLASS*DW-1:0]   in_data,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IDXW-1:0]         class_idx,
    output logic [DW-1:0]           class_val,
`ifdef FC_ARGMAX_TOP2_EN
    output logic [IDXW-1:0]         second_idx,
    output logic [DW:0]             margin,
`endif
    output logic                    all_zero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    localparam logic [IDXW-1:0] LAST = IDXW'(N_CLASS - 1);

    state_t                r_state;
    state_t                w_next;
    logic signed [DW-1:0]  r_bank [N_CLASS];
    logic [IDXW-1:0]       r_ptr;
    logic signed [DW-1:0]  r_best_val;
    logic [IDXW-1:0]       r_best_idx;
    logic [IDXW-1:0]       r_class_idx;
    logic signed [DW-1:0]  r_class_val;
    logic                  r_all_zero;

    logic signed [DW-1:0]  w_elem;
    logic                  w_gt;
    logic signed [DW-1:0]  w_best_val;
    logic [IDXW-1:0]       w_best_idx;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_SCAN;
            S_SCAN:  if (r_ptr == LAST) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Strict compare keeps the lowest index on ties
    always_comb begin
        w_elem     = r_bank[r_ptr];
        w_gt       = w_elem > r_best_val;
        w_best_val = w_gt ? w_elem : r_best_val;
        w_best_idx = w_gt ? r_ptr : r_best_idx;
    end

`ifdef FC_ARGMAX_TOP2_EN
    logic signed [DW-1:0]  r_sec_val;
    logic [IDXW-1:0]       r_sec_idx;
    logic [IDXW-1:0]       r_second_idx;
    logic [DW:0]           r_margin;
    logic                  w_sec_gt;
    logic signed [DW-1:0]  w_sec_val;
    logic [IDXW-1:0]       w_sec_idx;

    // A displaced best drops to second; a value tying best also lands here
    always_comb begin
        w_sec_gt  = w_elem > r_sec_val;
        w_sec_val = r_sec_val;
        w_sec_idx = r_sec_idx;
        if (w_gt) begin
            w_sec_val = r_best_val;
            w_sec_idx = r_best_idx;
        end else if (w_sec_gt) begin
            w_sec_val = w_elem;
            w_sec_idx = r_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sec_val    <= '0;
            r_sec_idx    <= '0;
            r_second_idx <= '0;
            r_margin     <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_sec_val <= {1'b1, {(DW-1){1'b0}}};
            r_sec_idx <= '0;
        end else if (r_state == S_SCAN) begin
            r_sec_val <= w_sec_val;
            r_sec_idx <= w_sec_idx;
            if (r_ptr == LAST) begin
                r_second_idx <= w_sec_idx;
                r_margin     <= {w_best_val[DW-1], w_best_val}
                              - {w_sec_val[DW-1], w_sec_val};
            end
        end
    end

    assign second_idx = r_second_idx;
    assign margin     = r_margin;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_best_val  <= '0;
            r_best_idx  <= '0;
            r_class_idx <= '0;
            r_class_val <= '0;
            r_all_zero  <= 1'b0;
            for (int k = 0; k < N_CLASS; k++) r_bank[k] <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int k = 0; k < N_CLASS; k++)
                            r_bank[k] <= in_data[k*DW +: DW];
                        r_best_val <= in_data[DW-1:0];
                        r_best_idx <= '0;
                        r_ptr      <= IDXW'(1);
                    end
                end
                S_SCAN: begin
                    r_best_val <= w_best_val;
                    r_best_idx <= w_best_idx;
                    r_ptr      <= r_ptr + IDXW'(1);
                    if (r_ptr == LAST) begin
                        r_class_idx <= w_best_idx;
                        r_class_val <= w_best_val;
                        r_all_zero  <= (w_best_val <= 0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign class_idx = r_class_idx;
    assign class_val = r_class_val;
    assign all_zero  = r_all_zero;

endmodule

// File: doc/fc_argmax_classifier.md
Name: fc_argmax_classifier

Overview:
- Final classification stage downstream of the FC+ReLU layer.
- Captures the N_CLASS post-ReLU 16-bit signed scores in one cycle, then scans them sequentially at one comparison per cycle.
- Reports the winning class index and score to the output consumer over a valid/ready handshake.
- Exactly one result is produced per accepted start.

Parameters:
- N_CLASS, 10, number of class scores; legal range 2..16.
- DW, 16, width of each signed score.
- IDXW, 4, width of the class index; must satisfy 2^IDXW >= N_CLASS.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to classify; sampled only in IDLE.
- in_data  input  N_CLASS*DW  packed scores, class k at bits [k*DW +: DW], signed.
- busy  output  1  high in SCAN and DONE.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- class_idx  output  IDXW  index of the maximum score.
- class_val  output  DW  maximum score, signed.
- all_zero  output  1  asserted when class_val <= 0 (no positive ReLU activation).

Behaviour:
- Reset: rst high at a clk edge forces state IDLE and clears all registers. out_valid, busy, class_idx, class_val and all_zero all read 0. Reset wins over every other input, including mid-SCAN and DONE; any partial result is discarded.
- States:
  - IDLE: wait for start.
  - SCAN: compare one stored score per cycle.
  - DONE: hold the result until the handshake completes.
- IDLE to SCAN: on cycle T with start=1:
  - register all of in_data into an internal score bank;
  - best_val = score0, best_idx = 0, ptr = 1.
  - in_data is ignored at all other times; upstream may change it after T.
- SCAN, each cycle:
  - if score[ptr] > best_val (signed, strict), then best_val = score[ptr] and best_idx = ptr;
  - ptr increments;
  - after comparing ptr = N_CLASS-1, go to DONE.
- Ties: the lowest index wins, because the comparison is strict.
- DONE:
  - class_idx, class_val and all_zero are registered, and out_valid=1 starting cycle T+N_CLASS (T+10 at default).
  - Outputs stay stable while out_valid=1 and out_ready=0.
- Handshake: a transfer occurs on a cycle with out_valid=1 and out_ready=1. On the next cycle out_valid=0 and the state returns to IDLE. Result outputs keep their last values until the next DONE.
- start handling:
  - start is ignored when busy=1 and is not queued.
  - start on the same cycle as the handshake is ignored; it must be re-asserted in IDLE.
  - Minimum start-to-start spacing is N_CLASS+1 cycles, given immediate out_ready.
- out_ready while out_valid=0 has no effect.
- Arithmetic: comparisons only, no accumulation, so there is no overflow. The most negative score (-2^(DW-1)) is handled as an ordinary value.

Optional Feature:
- Macro FC_ARGMAX_TOP2_EN.
- When defined, adds two outputs: second_idx (IDXW) and margin (DW+1 bits, unsigned), where margin = best_val - second_val.
- Tracking during SCAN:
  - second_val initialises to -2^(DW-1) and second_idx to 0.
  - if elem > best: second takes the old best, and best takes elem;
  - else if elem > second: second takes elem.
  - Consequently a value equal to best goes to second.
- Both new outputs follow the same reset, valid and hold rules as class_idx.
- When undefined, these ports and their logic are absent. Base behaviour is identical in both builds.

Test Plan:
1. Scores {0,5,3,900,12,0,0,7,899,1}, start at T, out_ready=1 -> out_valid rises at T+10; class_idx=3, class_val=900, all_zero=0.
2. All scores 0 -> class_idx=0, class_val=0, all_zero=1. Separately, scores 40 at indices 2 and 6, others 0 -> class_idx=2 (tie goes to lowest index).
3. Signed check: score0=-32768, score9=-1, others -5 -> class_idx=9, class_val=-1, all_zero=1.
4. Hold out_ready=0 for 6 cycles after valid, and pulse start during SCAN and DONE -> outputs stable, no second result. Raise out_ready -> out_valid drops next cycle and the FSM returns to IDLE.
5. rst pulsed at T+4 mid-SCAN -> all outputs 0 the next cycle, out_valid never asserts. A new start then yields the correct result with latency 10.
6. With FC_ARGMAX_TOP2_EN and scores {10,30,30,2,...0} -> class_idx=1, second_idx=2, margin=0. With {100,0,...,60 at idx 7} -> second_idx=7, margin=40.
